// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// A start in IDLE captures the operand magnitude and sign. SHIFT then runs for N cycles.
// The final shift publishes bcd/negative/overflow, pulses done and returns to IDLE.
// The published outputs hold between completions and never expose scratch contents.
module bin_to_bcd_seq #(
    parameter int unsigned N      = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          binary,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(N + 1);

    // Saturation pattern: every digit reads 9.
    function automatic logic [BcdW-1:0] all_nines();
        logic [BcdW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'd9;
        end
        return v;
    endfunction

    localparam logic [BcdW-1:0] Nines = all_nines();

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      mag_q, mag_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic              neg_next_q, neg_next_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              negative_q, negative_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    // Datapath signals shared by the FSM
    logic              in_neg;
    logic [N-1:0]      in_mag;
    logic [BcdW-1:0]   scratch_adj;
    logic [BcdW-1:0]   scratch_shift;
    logic [N-1:0]      mag_shift;
    logic              carry_out;

    // Operand magnitude; -2^(N-1) negates to itself, which is the correct unsigned magnitude.
    always_comb begin
        in_neg = signed_mode & binary[N-1];
        in_mag = in_neg ? (~binary + N'(1)) : binary;
    end

    // Add-3 correction on each digit, then shift {scratch, magnitude} left by one.
    always_comb begin
        scratch_adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        carry_out     = scratch_adj[BcdW-1];
        scratch_shift = {scratch_adj[BcdW-2:0], mag_q[N-1]};
        mag_shift     = {mag_q[N-2:0], 1'b0};
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        neg_next_d = neg_next_q;
        bcd_d      = bcd_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mag_d      = in_mag;
                    neg_next_d = in_neg;
                    scratch_d  = '0;
                    sticky_d   = 1'b0;
                    cnt_d      = CntW'(N);
                    state_d    = StShift;
                end
            end
            StShift: begin
                scratch_d = scratch_shift;
                mag_d     = mag_shift;
                // Any 1 leaving the top digit means the magnitude reached 10^DIGITS.
                sticky_d  = sticky_q | carry_out;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    bcd_d      = sticky_d ? Nines : scratch_shift;
                    negative_d = neg_next_q;
                    overflow_d = sticky_d;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mag_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            neg_next_q <= 1'b0;
            bcd_q      <= '0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            neg_next_q <= neg_next_d;
            bcd_q      <= bcd_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // Output drive
    always_comb begin
        busy     = (state_q == StShift);
        done     = done_q;
        bcd      = bcd_q;
        negative = negative_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed table, random vs. arithmetic model,
// handshake/reset sequences, and N=8/DIGITS=3 plus N=20/DIGITS=7 instances.
module tb_bin_to_bcd_seq;

    localparam int unsigned N0 = 20;
    localparam int unsigned D0 = 6;
    localparam int unsigned N1 = 8;
    localparam int unsigned D1 = 3;
    localparam int unsigned N2 = 20;
    localparam int unsigned D2 = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start0, sm0, busy0, done0, neg0, ovf0;
    logic [19:0]   bin0;
    logic [23:0]   bcd0;
    logic          start1, sm1, busy1, done1, neg1, ovf1;
    logic [7:0]    bin1;
    logic [11:0]   bcd1;
    logic          start2, sm2, busy2, done2, neg2, ovf2;
    logic [19:0]   bin2;
    logic [27:0]   bcd2;

    bin_to_bcd_seq #(.N(N0), .DIGITS(D0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .binary(bin0), .signed_mode(sm0),
        .busy(busy0), .done(done0), .bcd(bcd0), .negative(neg0), .overflow(ovf0)
    );
    bin_to_bcd_seq #(.N(N1), .DIGITS(D1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .binary(bin1), .signed_mode(sm1),
        .busy(busy1), .done(done1), .bcd(bcd1), .negative(neg1), .overflow(ovf1)
    );
    bin_to_bcd_seq #(.N(N2), .DIGITS(D2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .binary(bin2), .signed_mode(sm2),
        .busy(busy2), .done(done2), .bcd(bcd2), .negative(neg2), .overflow(ovf2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the signed/unsigned value.
    function automatic void model(input int unsigned n, input int unsigned d,
                                  input longint unsigned raw, input logic sm,
                                  output longint unsigned bcd, output logic neg,
                                  output logic ovf);
        longint unsigned mag, lim;
        neg = sm && raw[n-1];
        mag = neg ? ((64'd1 << n) - raw) : raw;
        lim = 1;
        for (int unsigned i = 0; i < d; i++) lim = lim * 10;
        ovf = (mag >= lim);
        bcd = 0;
        for (int unsigned i = 0; i < d; i++) begin
            if (ovf) begin
                bcd = bcd | (64'd9 << (4 * i));
            end else begin
                bcd = bcd | ((mag % 10) << (4 * i));
                mag = mag / 10;
            end
        end
    endfunction

    // Each conv task starts one conversion and returns edges from accept to done (-1 = timeout).
    task automatic conv0(input logic [19:0] b, input logic sm, output int lat);
        @(negedge clk); start0 = 1'b1; bin0 = b; sm0 = sm;
        @(posedge clk); #1 start0 = 1'b0;
        lat = -1;
        for (int k = 1; k <= int'(N0) + 5; k++) begin
            @(posedge clk); #1;
            if (done0) begin lat = k; break; end
        end
    endtask

    task automatic conv1(input logic [7:0] b, input logic sm, output int lat);
        @(negedge clk); start1 = 1'b1; bin1 = b; sm1 = sm;
        @(posedge clk); #1 start1 = 1'b0;
        lat = -1;
        for (int k = 1; k <= int'(N1) + 5; k++) begin
            @(posedge clk); #1;
            if (done1) begin lat = k; break; end
        end
    endtask

    task automatic conv2(input logic [19:0] b, input logic sm, output int lat);
        @(negedge clk); start2 = 1'b1; bin2 = b; sm2 = sm;
        @(posedge clk); #1 start2 = 1'b0;
        lat = -1;
        for (int k = 1; k <= int'(N2) + 5; k++) begin
            @(posedge clk); #1;
            if (done2) begin lat = k; break; end
        end
    endtask

    typedef struct {
        logic [19:0] bin;
        logic        sm;
        logic [23:0] bcd;
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int              lat, dones, first, d1, d2, saw;
        logic [23:0]     b1, b2;
        longint unsigned eb;
        logic            en, eo;
        logic [19:0]     rb;
        logic            rs;

        start0 = 0; bin0 = '0; sm0 = 0;
        start1 = 0; bin1 = '0; sm1 = 0;
        start2 = 0; bin2 = '0; sm2 = 0;

        vecs[0] = '{20'd0,       1'b0, 24'h000000, 1'b0, 1'b0};
        vecs[1] = '{20'd999999,  1'b0, 24'h999999, 1'b0, 1'b0};
        vecs[2] = '{20'd1000000, 1'b0, 24'h999999, 1'b0, 1'b1};
        vecs[3] = '{20'd1048575, 1'b0, 24'h999999, 1'b0, 1'b1};
        vecs[4] = '{20'hFCFC7,   1'b1, 24'h012345, 1'b1, 1'b0};
        vecs[5] = '{20'h80000,   1'b1, 24'h524288, 1'b1, 1'b0};
        vecs[6] = '{20'h80000,   1'b0, 24'h524288, 1'b0, 1'b0};
        vecs[7] = '{20'd0,       1'b1, 24'h000000, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_bcd", 64'(bcd0), 64'd0);
        check("rst_neg", 64'(neg0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            conv0(vecs[i].bin, vecs[i].sm, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(N0));
            check($sformatf("vec%0d_bcd", i), 64'(bcd0), 64'(vecs[i].bcd));
            check($sformatf("vec%0d_neg", i), 64'(neg0), 64'(vecs[i].neg));
            check($sformatf("vec%0d_ovf", i), 64'(ovf0), 64'(vecs[i].ovf));
        end

        // Random operands against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            rb = 20'($urandom);
            rs = 1'($urandom_range(0, 1));
            conv0(rb, rs, lat);
            model(N0, D0, 64'(rb), rs, eb, en, eo);
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(N0));
            check($sformatf("rnd%0d_bcd", i), 64'(bcd0), eb);
            check($sformatf("rnd%0d_neg", i), 64'(neg0), 64'(en));
            check($sformatf("rnd%0d_ovf", i), 64'(ovf0), 64'(eo));
        end

        // A start pulse while busy is ignored
        @(negedge clk); start0 = 1'b1; bin0 = 20'd111111; sm0 = 1'b0;
        @(posedge clk); #1 start0 = 1'b0;
        dones = 0; first = -1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin start0 = 1'b1; bin0 = 20'd222222; end
            if (k == 6) start0 = 1'b0;
            @(posedge clk); #1;
            if (done0) begin dones++; if (first < 0) first = k; end
            if (k == 5) check("ign_busy_mid", 64'(busy0), 64'd1);
            if (k == 20) check("ign_busy_fall", 64'(busy0), 64'd0);
        end
        check("ign_done_count", 64'(dones), 64'd1);
        check("ign_done_at", 64'(first), 64'(N0));
        check("ign_bcd", 64'(bcd0), 64'h111111);

        // start held high: the done cycle is IDLE, so the next operand is accepted
        // on the edge after the done edge
        @(negedge clk); start0 = 1'b1; bin0 = 20'd42; sm0 = 1'b0;
        @(posedge clk); #1;
        d1 = -1; d2 = -1; b1 = '0; b2 = '0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            if (d1 > 0 && d2 < 0 && k == d1 + 1) begin
                check("b2b_done_single", 64'(done0), 64'd0);
                check("b2b_busy_again", 64'(busy0), 64'd1);
            end
            if (done0) begin
                if (d1 < 0) begin
                    d1 = k; b1 = bcd0; bin0 = 20'd7;
                end else if (d2 < 0) begin
                    d2 = k; b2 = bcd0; start0 = 1'b0;
                end
            end
        end
        start0 = 1'b0;
        check("b2b_first_at", 64'(d1), 64'(N0));
        check("b2b_first_bcd", 64'(b1), 64'h000042);
        check("b2b_second_at", 64'(d2), 64'(2 * N0 + 1));
        check("b2b_second_bcd", 64'(b2), 64'h000007);

        // Reset mid-conversion, starting from non-zero held outputs
        conv0(20'hFCFC7, 1'b1, lat);
        check("pre_rst_neg", 64'(neg0), 64'd1);
        @(negedge clk); start0 = 1'b1; bin0 = 20'd654321; sm0 = 1'b0;
        @(posedge clk); #1 start0 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 64'(busy0), 64'd0);
        check("mid_rst_done", 64'(done0), 64'd0);
        check("mid_rst_bcd", 64'(bcd0), 64'd0);
        check("mid_rst_neg", 64'(neg0), 64'd0);
        check("mid_rst_ovf", 64'(ovf0), 64'd0);
        rst = 1'b0;
        saw = 0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (done0) saw = 1;
        end
        check("mid_rst_no_done", 64'(saw), 64'd0);
        conv0(20'd123456, 1'b0, lat);
        check("post_rst_lat", 64'(lat), 64'(N0));
        check("post_rst_bcd", 64'(bcd0), 64'h123456);

        // N=8, DIGITS=3: every value in both modes
        for (int v = 0; v < 256; v++) begin
            for (int s = 0; s < 2; s++) begin
                conv1(8'(v), 1'(s), lat);
                model(N1, D1, 64'(v), 1'(s), eb, en, eo);
                check($sformatf("n8_%0d_%0d_lat", v, s), 64'(lat), 64'(N1));
                check($sformatf("n8_%0d_%0d_bcd", v, s), 64'(bcd1), eb);
                check($sformatf("n8_%0d_%0d_neg", v, s), 64'(neg1), 64'(en));
                check($sformatf("n8_%0d_%0d_ovf", v, s), 64'(ovf1), 64'(eo));
            end
        end

        // N=20, DIGITS=7: full range fits without overflow
        conv2(20'hFFFFF, 1'b0, lat);
        check("d7_lat", 64'(lat), 64'(N2));
        check("d7_bcd", 64'(bcd2), 64'h1048575);
        check("d7_ovf", 64'(ovf2), 64'd0);
        for (int i = 0; i < 20; i++) begin
            rb = 20'($urandom);
            rs = 1'($urandom_range(0, 1));
            conv2(rb, rs, lat);
            model(N2, D2, 64'(rb), rs, eb, en, eo);
            check($sformatf("d7rnd%0d_bcd", i), 64'(bcd2), eb);
            check($sformatf("d7rnd%0d_neg", i), 64'(neg2), 64'(en));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
